// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU with A/B registers, Z/C flags
// and a registered single-port memory interface.
module acc_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              we,
    output logic              halted,
    output logic              flag_z,
    output logic              flag_c,
    output logic [DATA_W-1:0] acc
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_OPERAND = 3'd2;
    localparam logic [2:0] S_MEM_RD  = 3'd3;
    localparam logic [2:0] S_STORE   = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] b;
    logic [7:0]        inst;

    logic [7:0]        op;
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] b_n;
    logic              z_n;
    logic              c_n;
    logic              two_word;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] opr_addr;

    assign pc_inc   = pc + ADDR_W'(1);
    assign opr_addr = ADDR_W'(data_in);

    // One-word ops resolve combinationally from the word on data_in.
    always_comb begin
        op       = data_in[7:0];
        wide     = '0;
        res      = acc;
        b_n      = b;
        z_n      = flag_z;
        c_n      = flag_c;
        two_word = 1'b0;
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04,
            8'h20, 8'h21, 8'h22: two_word = 1'b1;
            8'h05: b_n = acc;
            8'h10: begin
                wide = {1'b0, acc} + {1'b0, b};
                res  = wide[DATA_W-1:0];
                c_n  = wide[DATA_W];
            end
            8'h11: begin
                wide = {1'b0, acc} - {1'b0, b};
                res  = wide[DATA_W-1:0];
                c_n  = wide[DATA_W];
            end
            8'h12: begin
                c_n = acc[DATA_W-1];
                res = {acc[DATA_W-2:0], 1'b0};
            end
            8'h13: begin
                c_n = acc[0];
                res = {1'b0, acc[DATA_W-1:1]};
            end
            8'h14: res = acc & b;
            8'h15: res = acc | b;
            8'h16: res = acc ^ b;
            8'h17: res = ~acc;
            default: ;
        endcase
        if (op[7:3] == 5'b00010) begin
            z_n = (res == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            addr     <= RESET_PC;
            acc      <= '0;
            b        <= '0;
            inst     <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            data_out <= '0;
            we       <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    inst <= op;
                    pc   <= pc_inc;
                    addr <= pc_inc;
                    if (op == 8'hFF) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (two_word) begin
                        state <= S_OPERAND;
                    end else begin
                        acc    <= res;
                        b      <= b_n;
                        flag_z <= z_n;
                        flag_c <= c_n;
                        state  <= S_FETCH;
                    end
                end
                S_OPERAND: begin
                    pc    <= pc_inc;
                    addr  <= pc_inc;
                    state <= S_FETCH;
                    case (inst)
                        8'h01: begin
                            acc    <= data_in;
                            flag_z <= (data_in == '0);
                        end
                        8'h02: b <= data_in;
                        8'h03: begin
                            addr  <= opr_addr;
                            state <= S_MEM_RD;
                        end
                        8'h04: begin
                            addr     <= opr_addr;
                            data_out <= acc;
                            we       <= 1'b1;
                            state    <= S_STORE;
                        end
                        8'h20: begin
                            pc   <= opr_addr;
                            addr <= opr_addr;
                        end
                        8'h21: if (flag_z) begin
                            pc   <= opr_addr;
                            addr <= opr_addr;
                        end
                        8'h22: if (flag_c) begin
                            pc   <= opr_addr;
                            addr <= opr_addr;
                        end
                        default: ;
                    endcase
                end
                S_MEM_RD: begin
                    acc    <= data_in;
                    flag_z <= (data_in == '0);
                    addr   <= pc;
                    state  <= S_FETCH;
                end
                S_STORE: begin
                    we    <= 1'b0;
                    addr  <= pc;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    we     <= 1'b0;
                    halted <= 1'b1;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
